// File: rtl/galois_stream_checker_if.sv
// rtl/galois_stream_checker_if.sv - serial bit stream bundle feeding the Galois LFSR checker
// Purpose: groups the serial stream bit and its valid strobe.
// Signals:
//   bit_in    - serial stream bit from the generator (MSB stage)
//   bit_valid - bit_in is sampled on a rising edge only when high
// Modports: master drives the stream, slave (the checker) consumes it.
interface galois_stream_checker_if;
  logic bit_in;
  logic bit_valid;

  modport master (output bit_in, output bit_valid);
  modport slave  (input  bit_in, input  bit_valid);
endinterface

// File: rtl/galois_stream_checker.sv
// rtl/galois_stream_checker.sv - self-synchronising error checker for the 32-bit Galois LFSR stream
// Purpose: fills a 32-bit history from the incoming stream, verifies it against
//   the recurrence of x32+x30+x17+x12+x3+x+1, locks after LOCK_GOOD matches,
//   then flywheels on its own prediction, counting mismatches and dropping lock
//   when LOSS_THRESH errors land inside one WIN_LEN-bit window.
// Ports:
//   clk       - rising-edge clock
//   clear_n   - synchronous active-low reset
//   s         - stream slave: s.bit_in, s.bit_valid
//   cnt_clr   - synchronously zero err_cnt
//   locked    - 1 while in LOCKED
//   err_pulse - one cycle: previous accepted bit mismatched while LOCKED
//   lost      - one cycle: LOCKED -> FILL transition
//   zero_seq  - 1 while VERIFY holds an all-zero history
//   err_cnt   - saturating 16-bit count of LOCKED mismatches
module galois_stream_checker #(
  parameter logic [31:0] TAPS        = 32'hD0084002,
  parameter int          LOCK_GOOD   = 64,
  parameter int          WIN_LEN     = 1024,
  parameter int          LOSS_THRESH = 8
) (
  input  logic                    clk,
  input  logic                    clear_n,
  galois_stream_checker_if.slave  s,
  input  logic                    cnt_clr,
  output logic                    locked,
  output logic                    err_pulse,
  output logic                    lost,
  output logic                    zero_seq,
  output logic [15:0]             err_cnt
);

  localparam int WIN_W = $clog2(WIN_LEN);
  localparam int ERR_W = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      hist_q, hist_d;
  logic [4:0]       fill_q, fill_d;
  logic [7:0]       good_q, good_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0] win_err_q, win_err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             lost_q, lost_d;
  logic             zero_seq_q, zero_seq_d;

  logic             pred;
  logic             mismatch;
  logic             wrap;
  logic [ERR_W-1:0] win_err_base;

  assign pred     = ^(hist_q & TAPS);
  assign mismatch = s.bit_in ^ pred;
  assign wrap     = (win_cnt_q == WIN_W'(WIN_LEN - 1));
  // On the wrap bit the old window is discarded first, so an error there opens the new window.
  assign win_err_base = wrap ? '0 : win_err_q;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    good_d      = good_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    lost_d      = 1'b0;
    zero_seq_d  = zero_seq_q;
    // Clear applies before any error counted on the same edge.
    err_cnt_d   = cnt_clr ? 16'h0000 : err_cnt_q;

    if (s.bit_valid) begin
      case (state_q)
        ST_FILL: begin
          hist_d = {hist_q[30:0], s.bit_in};
          if (fill_q == 5'd31) begin
            fill_d  = 5'd0;
            good_d  = 8'd0;
            state_d = ST_VERIFY;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        ST_VERIFY: begin
          hist_d = {hist_q[30:0], s.bit_in};
          if (hist_q == 32'h0 || mismatch) begin
            // All-zero history predicts zero trivially; never credit it.
            good_d = 8'd0;
          end else if (good_q == 8'(LOCK_GOOD - 1)) begin
            good_d    = 8'd0;
            win_cnt_d = '0;
            win_err_d = '0;
            state_d   = ST_LOCKED;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
        ST_LOCKED: begin
          // Flywheel: history follows the prediction so one bad bit costs one error.
          hist_d    = {hist_q[30:0], pred};
          win_cnt_d = wrap ? '0 : win_cnt_q + 1'b1;
          win_err_d = win_err_base;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            win_err_d   = win_err_base + 1'b1;
            if (err_cnt_d != 16'hFFFF) begin
              err_cnt_d = err_cnt_d + 16'd1;
            end
          end
          if (win_err_d == ERR_W'(LOSS_THRESH)) begin
            state_d = ST_FILL;
            fill_d  = 5'd0;
            good_d  = 8'd0;
            lost_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_FILL;
          fill_d  = 5'd0;
          good_d  = 8'd0;
        end
      endcase
      zero_seq_d = (state_q == ST_VERIFY) && (state_d == ST_VERIFY) && (hist_d == 32'h0);
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= ST_FILL;
      hist_q      <= 32'h0;
      fill_q      <= 5'd0;
      good_q      <= 8'd0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= 16'h0000;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lost_q      <= 1'b0;
      zero_seq_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lost_q      <= lost_d;
      zero_seq_q  <= zero_seq_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign lost      = lost_q;
  assign zero_seq  = zero_seq_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_galois_stream_checker.sv
// tb/tb_galois_stream_checker.sv - directed self-checking bench for galois_stream_checker
module tb_galois_stream_checker;

  localparam logic [31:0] POLY = 32'h4002100B;

  logic        clk;
  logic        clear_n;
  logic        cnt_clr;
  logic        locked;
  logic        err_pulse;
  logic        lost;
  logic        zero_seq;
  logic [15:0] err_cnt;

  galois_stream_checker_if sif ();

  galois_stream_checker dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .s         (sif),
    .cnt_clr   (cnt_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .lost      (lost),
    .zero_seq  (zero_seq),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          idle_pulses;
  logic [31:0] gen;

  // Left-shifting Galois generator; its output is the MSB stage.
  task automatic gen_step(output logic b);
    b   = gen[31];
    gen = {gen[30:0], 1'b0} ^ (b ? POLY : 32'h0);
  endtask

  function automatic int pick_gap(input int gmax);
    if (gmax == 0) return 0;
    return int'($urandom_range(gmax, 1));
  endfunction

  task automatic do_reset();
    sif.bit_valid = 1'b0;
    cnt_clr       = 1'b0;
    clear_n       = 1'b0;
    @(posedge clk);
    #1;
    clear_n = 1'b1;
  endtask

  task automatic send_raw(input logic b, input int gap, input logic clr);
    for (int g = 0; g < gap; g++) begin
      sif.bit_valid = 1'b0;
      cnt_clr       = 1'b0;
      @(posedge clk);
      #1;
      if (err_pulse !== 1'b0 || lost !== 1'b0) idle_pulses++;
    end
    sif.bit_in    = b;
    sif.bit_valid = 1'b1;
    cnt_clr       = clr;
    @(posedge clk);
    #1;
    sif.bit_valid = 1'b0;
    cnt_clr       = 1'b0;
  endtask

  task automatic send_gen(input logic flip, input int gap, input logic clr);
    logic b;
    gen_step(b);
    send_raw(b ^ flip, gap, clr);
  endtask

  task automatic lock_up(input int gmax);
    gen = 32'h0000_0001;
    do_reset();
    for (int i = 0; i < 96; i++) send_gen(1'b0, pick_gap(gmax), 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({locked, err_pulse, lost, zero_seq, err_cnt} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 00000", {locked, err_pulse, lost, zero_seq, err_cnt});
    end
  endtask

  task automatic test_clean_lock(input int gmax);
    int first_lock;
    int pulses;
    gen = 32'h0000_0001;
    do_reset();
    first_lock  = 0;
    pulses      = 0;
    idle_pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      send_gen(1'b0, pick_gap(gmax), 1'b0);
      if (locked === 1'b1 && first_lock == 0) first_lock = i;
      if (err_pulse !== 1'b0) pulses++;
    end
    checks++;
    if (first_lock !== 96) begin
      errors++;
      $display("FAIL clean_lock_bit gap%0d: got %0d expected 96", gmax, first_lock);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_locked gap%0d: got %b expected 1", gmax, locked);
    end
    checks++;
    if (err_cnt !== 16'd0 || pulses !== 0) begin
      errors++;
      $display("FAIL clean_errs gap%0d: got cnt=%0d pulses=%0d expected 0/0", gmax, err_cnt, pulses);
    end
  endtask

  task automatic test_single_flip(input int gmax);
    int pulses;
    int unlocked;
    lock_up(gmax);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL flip_prelock gap%0d: got %b expected 1", gmax, locked);
    end
    for (int i = 0; i < 10; i++) send_gen(1'b0, pick_gap(gmax), 1'b0);
    idle_pulses = 0;
    send_gen(1'b1, pick_gap(gmax), 1'b0);
    checks++;
    if ({err_pulse, lost, locked} !== 3'b101 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flip_pulse gap%0d: got pulse/lost/locked=%b cnt=%0d expected 101 cnt=1",
               gmax, {err_pulse, lost, locked}, err_cnt);
    end
    pulses   = 0;
    unlocked = 0;
    for (int i = 0; i < 100; i++) begin
      send_gen(1'b0, pick_gap(gmax), 1'b0);
      if (err_pulse !== 1'b0) pulses++;
      if (locked !== 1'b1) unlocked++;
    end
    checks++;
    if (pulses !== 0 || unlocked !== 0 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flip_after gap%0d: got pulses=%0d unlocked=%0d cnt=%0d expected 0/0/1",
               gmax, pulses, unlocked, err_cnt);
    end
    checks++;
    if (idle_pulses !== 0) begin
      errors++;
      $display("FAIL flip_idle_pulses gap%0d: got %0d expected 0", gmax, idle_pulses);
    end
  endtask

  task automatic test_burst_loss();
    int early;
    int relock;
    int lost_late;
    lock_up(0);
    early = 0;
    for (int k = 1; k <= 7; k++) begin
      send_gen(1'b1, 0, 1'b0);
      if (lost !== 1'b0 || locked !== 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL burst_early_loss: got %0d expected 0", early);
    end
    send_gen(1'b1, 0, 1'b0);
    checks++;
    if ({lost, err_pulse, locked} !== 3'b110) begin
      errors++;
      $display("FAIL burst_lost: got lost/pulse/locked=%b expected 110", {lost, err_pulse, locked});
    end
    relock    = 0;
    lost_late = 0;
    for (int i = 1; i <= 200; i++) begin
      send_gen(1'b0, 0, 1'b0);
      if (lost !== 1'b0) lost_late++;
      if (locked === 1'b1 && relock == 0) relock = i;
    end
    checks++;
    if (relock !== 96 || lost_late !== 0) begin
      errors++;
      $display("FAIL burst_relock: got bit=%0d lostpulses=%0d expected 96/0", relock, lost_late);
    end
    checks++;
    if (err_cnt !== 16'd8) begin
      errors++;
      $display("FAIL burst_errcnt_held: got %0d expected 8", err_cnt);
    end
  endtask

  task automatic test_window_wrap();
    int lost_seen;
    lock_up(0);
    lost_seen = 0;
    for (int k = 0; k < 7; k++) begin
      send_gen(1'b1, 0, 1'b0);
      if (lost !== 1'b0) lost_seen++;
      send_gen(1'b0, 0, 1'b0);
    end
    for (int i = 0; i < 1024; i++) begin
      send_gen(1'b0, 0, 1'b0);
      if (lost !== 1'b0) lost_seen++;
    end
    for (int k = 0; k < 7; k++) begin
      send_gen(1'b1, 0, 1'b0);
      if (lost !== 1'b0) lost_seen++;
      send_gen(1'b0, 0, 1'b0);
    end
    checks++;
    if (lost_seen !== 0 || locked !== 1'b1 || err_cnt !== 16'd14) begin
      errors++;
      $display("FAIL window_wrap: got lost=%0d locked=%b cnt=%0d expected 0/1/14", lost_seen, locked, err_cnt);
    end
  endtask

  // Errors at window positions 1016..1030: seven in the first window, the one on
  // the wrap bit (1023) opens the second window, and the 8th in that window is 1030.
  task automatic test_wrap_boundary();
    int early;
    lock_up(0);
    early = 0;
    for (int p = 0; p <= 1030; p++) begin
      send_gen(p >= 1016, 0, 1'b0);
      if (p < 1030 && lost !== 1'b0) early++;
    end
    checks++;
    if (early !== 0 || lost !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL wrap_boundary: got early=%0d lost=%b locked=%b expected 0/1/0", early, lost, locked);
    end
  endtask

  task automatic test_zero_stream();
    logic zs32;
    logic zs33;
    int   ever_locked;
    do_reset();
    zs32        = 1'b0;
    zs33        = 1'b0;
    ever_locked = 0;
    for (int i = 1; i <= 500; i++) begin
      send_raw(1'b0, 0, 1'b0);
      if (i == 32) zs32 = zero_seq;
      if (i == 33) zs33 = zero_seq;
      if (locked !== 1'b0) ever_locked++;
    end
    checks++;
    if (zs32 !== 1'b0 || zs33 !== 1'b1) begin
      errors++;
      $display("FAIL zero_seq_onset: got bit32=%b bit33=%b expected 0/1", zs32, zs33);
    end
    checks++;
    if (ever_locked !== 0 || zero_seq !== 1'b1) begin
      errors++;
      $display("FAIL zero_never_locks: got locked_cycles=%0d zero_seq=%b expected 0/1", ever_locked, zero_seq);
    end
  endtask

  task automatic test_reset_clear();
    lock_up(0);
    send_gen(1'b1, 0, 1'b0);
    clear_n       = 1'b0;
    sif.bit_in    = 1'b1;
    sif.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    clear_n       = 1'b1;
    sif.bit_valid = 1'b0;
    checks++;
    if ({locked, err_pulse, lost, zero_seq, err_cnt} !== 20'h0) begin
      errors++;
      $display("FAIL reset_midlock: got %h expected 00000", {locked, err_pulse, lost, zero_seq, err_cnt});
    end
    lock_up(0);
    send_gen(1'b1, 0, 1'b0);
    send_gen(1'b0, 0, 1'b0);
    send_gen(1'b1, 0, 1'b0);
    checks++;
    if (err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL clr_precount: got %0d expected 2", err_cnt);
    end
    send_gen(1'b1, 0, 1'b1);
    checks++;
    if (err_cnt !== 16'd1 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_error: got cnt=%0d pulse=%b expected 1/1", err_cnt, err_pulse);
    end
    sif.bit_valid = 1'b0;
    cnt_clr       = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    checks++;
    if (err_cnt !== 16'd0 || locked !== 1'b1 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle: got cnt=%0d locked=%b pulse=%b expected 0/1/0", err_cnt, locked, err_pulse);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    idle_pulses   = 0;
    gen           = 32'h0000_0001;
    clear_n       = 1'b0;
    cnt_clr       = 1'b0;
    sif.bit_in    = 1'b0;
    sif.bit_valid = 1'b0;

    test_reset();
    test_clean_lock(0);
    test_single_flip(0);
    test_burst_loss();
    test_window_wrap();
    test_wrap_boundary();
    test_zero_stream();
    test_reset_clear();
    test_clean_lock(5);
    test_single_flip(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
